receiver: RTL and testbench

//  Serial receive end of the transceiver's asynchronous link: deserialises frames of
//  1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1), idle line = 1.

---
 rtl/receiver.sv | 174 +++++++++++++++++
 tb/tb_receiver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/receiver.sv
// Asynchronous serial receiver: 2-flop synchronised line, mid-bit sampling at
// OVERSAMPLE clocks per bit, valid/ack byte handoff with framing and overrun flags.
module receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 send_clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_status,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_sync;
  logic                  r_din_d;
  logic [TW-1:0]         r_tick;
  logic [BW-1:0]         r_bit;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_load_ok;
  logic                  r_load_bad;
  logic                  r_status;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_valid;
  logic                  r_ferr;
  logic                  r_ovr;

  logic w_din_s;
  logic w_fall;
  logic w_tick_clr;
  logic w_tick_inc;
  logic w_bit_clr;
  logic w_bit_inc;
  logic w_shift_en;
  logic w_stop_ok;
  logic w_stop_bad;

  assign w_din_s = r_sync[1];
  assign w_fall  = !w_din_s && r_din_d;

  always_ff @(posedge send_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_din_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], din};
      r_din_d <= w_din_s;
    end
  end

  always_ff @(posedge send_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_fall) w_state_next = START;
      // Mid-start check rejects glitches shorter than half a bit
      START: if (r_tick == TICK_HALF) w_state_next = w_din_s ? IDLE : DATA;
      DATA:  if (r_tick == TICK_LAST && r_bit == BIT_LAST) w_state_next = STOP;
      STOP:  if (r_tick == TICK_LAST) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_tick_clr = 1'b0;
    w_tick_inc = 1'b0;
    w_bit_clr  = 1'b0;
    w_bit_inc  = 1'b0;
    w_shift_en = 1'b0;
    w_stop_ok  = 1'b0;
    w_stop_bad = 1'b0;
    case (r_state)
      IDLE: begin
        w_tick_clr = 1'b1;
        w_bit_clr  = 1'b1;
      end
      START: begin
        if (r_tick == TICK_HALF) begin
          w_tick_clr = 1'b1;
          w_bit_clr  = 1'b1;
        end else begin
          w_tick_inc = 1'b1;
        end
      end
      DATA: begin
        if (r_tick == TICK_LAST) begin
          w_tick_clr = 1'b1;
          w_shift_en = 1'b1;
          w_bit_inc  = (r_bit != BIT_LAST);
        end else begin
          w_tick_inc = 1'b1;
        end
      end
      STOP: begin
        if (r_tick == TICK_LAST) begin
          w_tick_clr = 1'b1;
          w_stop_ok  = w_din_s;
          w_stop_bad = !w_din_s;
        end else begin
          w_tick_inc = 1'b1;
        end
      end
      default: w_tick_clr = 1'b1;
    endcase
  end

  always_ff @(posedge send_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_load_ok  <= 1'b0;
      r_load_bad <= 1'b0;
      r_status   <= 1'b1;
    end else begin
      if (w_tick_clr)      r_tick <= '0;
      else if (w_tick_inc) r_tick <= r_tick + 1'b1;
      if (w_bit_clr)       r_bit <= '0;
      else if (w_bit_inc)  r_bit <= r_bit + 1'b1;
      if (w_shift_en)      r_shift <= {w_din_s, r_shift[DATA_BITS-1:1]};
      r_load_ok  <= w_stop_ok;
      r_load_bad <= w_stop_bad;
      r_status   <= (r_state == IDLE);
    end
  end

  // A load in the same cycle as an ack consumes the old byte, so no overrun
  always_ff @(posedge send_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (r_load_ok) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_ferr  <= 1'b0;
        if (r_valid && !rx_ack)     r_ovr <= 1'b1;
        else if (r_valid && rx_ack) r_ovr <= 1'b0;
      end else begin
        if (r_load_bad) r_ferr <= 1'b1;
        if (r_valid && rx_ack) begin
          r_valid <= 1'b0;
          r_ovr   <= 1'b0;
        end
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign rx_status = r_status;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_receiver.sv
// Scoreboarded bench for receiver: directed frames plus a 256-byte random loopback.
module tb_receiver;

  logic       send_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic       din      = 1'b1;
  logic       rx_ack   = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_status;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .send_clk (send_clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_status(rx_status),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 send_clk = ~send_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Model of the transmitter: start 0, 8 data LSB first, stop, 16 clocks per bit
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    if (stop) exp_q.push_back(d);
    @(posedge send_clk); #1;
    for (int i = 0; i < 10; i++) begin
      din = f[i];
      repeat (16) @(posedge send_clk);
      #1;
    end
    din = 1'b1;
  endtask

  task automatic ack_once();
    @(posedge send_clk); #1 rx_ack = 1'b1;
    @(posedge send_clk); #1 rx_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge send_clk);
    #1;
  endtask

  // Monitor: a new byte appears as a rising rx_valid or a change of rx_data while valid
  always @(negedge send_clk) begin
    if (rst_n && rx_valid && (!prev_valid || rx_data != prev_data)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_byte: got %02h expected none", rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL rx_byte: got %02h expected %02h", rx_data, e);
        end else begin
          $display("ok   rx_byte: %02h", rx_data);
        end
      end
    end
    prev_valid = rx_valid;
    prev_data  = rx_data;
  end

  initial begin
    idle(3);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_valid", rx_valid, 1'b0);
    chk("reset_status", rx_status, 1'b1);
    chk("reset_ferr", frame_err, 1'b0);
    chk("reset_ovr", overrun, 1'b0);
    rst_n = 1'b1;
    idle(5);

    send_frame(8'hA5, 1'b1);
    idle(4);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid", rx_valid, 1'b1);
    chk("a5_ferr", frame_err, 1'b0);
    chk("a5_status", rx_status, 1'b1);
    ack_once();
    idle(1);
    chk("a5_acked", rx_valid, 1'b0);

    // Short glitch: low for 4 clocks only
    @(posedge send_clk); #1 din = 1'b0;
    idle(4);
    din = 1'b1;
    idle(2);
    chk("glitch_busy", rx_status, 1'b0);
    idle(30);
    chk("glitch_status", rx_status, 1'b1);
    chk("glitch_valid", rx_valid, 1'b0);

    send_frame(8'h3C, 1'b0);
    idle(20);
    chk("bad_ferr", frame_err, 1'b1);
    chk("bad_valid", rx_valid, 1'b0);
    chk("bad_data", rx_data, 8'hA5);
    send_frame(8'h81, 1'b1);
    idle(4);
    chk("good_ferr", frame_err, 1'b0);
    chk("good_data", rx_data, 8'h81);
    ack_once();

    send_frame(8'h11, 1'b1);
    idle(4);
    chk("ovr_first", overrun, 1'b0);
    send_frame(8'h22, 1'b1);
    idle(4);
    chk("ovr_data", rx_data, 8'h22);
    chk("ovr_set", overrun, 1'b1);
    ack_once();
    idle(1);
    chk("ovr_ack_valid", rx_valid, 1'b0);
    chk("ovr_ack_clr", overrun, 1'b0);

    // Ack lands on the load edge of the second frame
    send_frame(8'h33, 1'b1);
    idle(4);
    fork
      send_frame(8'h44, 1'b1);
      begin
        repeat (156) @(posedge send_clk);
        #1 rx_ack = 1'b1;
        @(posedge send_clk); #1 rx_ack = 1'b0;
      end
    join
    idle(4);
    chk("sim_valid", rx_valid, 1'b1);
    chk("sim_data", rx_data, 8'h44);
    chk("sim_ovr", overrun, 1'b0);

    // Reset in the middle of a 0xFF frame
    @(posedge send_clk); #1 din = 1'b0;
    idle(16);
    din = 1'b1;
    idle(30);
    rst_n = 1'b0;
    #3;
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_valid", rx_valid, 1'b0);
    chk("mid_rst_status", rx_status, 1'b1);
    chk("mid_rst_ferr", frame_err, 1'b0);
    chk("mid_rst_ovr", overrun, 1'b0);
    idle(3);
    rst_n = 1'b1;
    idle(200);
    chk("post_rst_valid", rx_valid, 1'b0);
    send_frame(8'h5A, 1'b1);
    idle(4);
    chk("post_rst_data", rx_data, 8'h5A);
    ack_once();

    for (int n = 0; n < 256; n++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      idle(2);
      ack_once();
      idle(2);
    end
    chk("loop_ferr", frame_err, 1'b0);
    chk("loop_ovr", overrun, 1'b0);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
